// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FIFO read-side stream adapter
package fifo_pkg;

  localparam int FIFO_RD_LATENCY = 1;
  localparam int DEF_WIDTH       = 16;
  localparam int SKID_DEPTH      = 2;

  // Burst counter width; a single-word burst still needs a 1-bit counter.
  function automatic int burst_cnt_w(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry output buffer with registered head word
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] r_mem [SKID_DEPTH];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_dout;

  logic             w_pop;
  logic             w_push;
  logic             w_head_nxt;
  logic [1:0]       w_occ_nxt;
  logic [WIDTH-1:0] w_dout_nxt;

  assign w_pop      = pop && (r_occ != 2'd0);
  assign w_push     = push && ((r_occ != 2'(SKID_DEPTH)) || w_pop);
  assign w_head_nxt = r_head ^ w_pop;
  assign w_occ_nxt  = r_occ + {1'b0, w_push} - {1'b0, w_pop};

  // The head word is registered so dout keeps its last value once the buffer drains.
  always_comb begin
    w_dout_nxt = r_dout;
    if (w_occ_nxt != 2'd0) begin
      if (w_push && (r_tail == w_head_nxt)) begin
        w_dout_nxt = din;
      end else begin
        w_dout_nxt = r_mem[w_head_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= 2'd0;
      r_dout <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= din;
      end
      r_tail <= r_tail ^ w_push;
      r_head <= w_head_nxt;
      r_occ  <= w_occ_nxt;
      r_dout <= w_dout_nxt;
    end
  end

  assign dout = r_dout;
  assign occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream with burst last marking
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             fifo_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int            CW       = burst_cnt_w(BURST_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  logic [FIFO_RD_LATENCY-1:0] r_inflight;
  logic [CW-1:0]              r_burst_cnt;
  logic [1:0]                 w_occ;
  logic                       w_pop;
  logic [2:0]                 w_pending;

  assign out_valid = (w_occ != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign w_pending = {1'b0, w_occ} + {2'b0, r_inflight};

  // Issue a read only if the word it returns is guaranteed a buffer slot.
  assign rd_en    = rst_n && !fifo_empty && (w_pending < (3'd2 + {2'b0, w_pop}));
  assign out_last = out_valid && (r_burst_cnt == LAST_CNT);

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight[0]),
    .din   (rd_data),
    .pop   (w_pop),
    .dout  (out_data),
    .occ   (w_occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_inflight <= rd_en;
      if (w_pop) begin
        r_burst_cnt <= (r_burst_cnt == LAST_CNT) ? '0 : r_burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized and directed bench for fifo_rd_stream
module tb_fifo_rd_stream;

  localparam int W  = 16;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_en;
  logic [W-1:0] rd_data;
  logic         fifo_empty;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  fifo_rd_stream #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: FIFO contents, words read but not yet consumed with the cycle they become visible.
  logic [W-1:0] fq[$];
  logic [W-1:0] rq_d[$];
  int           rq_t[$];
  logic         pend;
  logic [W-1:0] pend_word;
  int           bidx;
  logic [W-1:0] last_data;

  logic         exp_valid, exp_pop, exp_rd_en, exp_last;
  logic [W-1:0] exp_data;

  task automatic tick(input bit rdy, input bit rstv);
    int nready;
    @(negedge clk);
    rst_n = rstv;
    if (!rstv) begin
      rq_d.delete();
      rq_t.delete();
      pend      = 1'b0;
      bidx      = 0;
      last_data = '0;
    end
    out_ready  = rdy;
    fifo_empty = (fq.size() == 0);
    rd_data    = pend ? pend_word : W'($urandom);
    #1;
    nready = 0;
    foreach (rq_t[i]) if (rq_t[i] <= cyc) nready++;
    exp_valid = (nready > 0);
    exp_pop   = exp_valid && rdy;
    exp_rd_en = rstv && !fifo_empty && ((rq_t.size() - int'(exp_pop)) < 2);
    exp_data  = exp_valid ? rq_d[0] : last_data;
    exp_last  = exp_valid && (bidx == BL - 1);
    if (exp_pop) begin
      last_data = rq_d.pop_front();
      void'(rq_t.pop_front());
      bidx = (bidx + 1) % BL;
    end
    pend = 1'b0;
    if (exp_rd_en) begin
      pend_word = fq.pop_front();
      pend      = 1'b1;
      rq_d.push_back(pend_word);
      rq_t.push_back(cyc + 2);
    end
    cyc++;
  endtask

  task automatic test_reset();
    fq.delete();
    fq.push_back(16'h1111);
    fq.push_back(16'h2222);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_cmp += 4;
      if (rd_en !== 1'b0) begin n_err++; $display("FAIL reset rd_en cyc=%0d got=%b exp=0", cyc, rd_en); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid cyc=%0d got=%b exp=0", cyc, out_valid); end
      if (out_last !== 1'b0) begin n_err++; $display("FAIL reset out_last cyc=%0d got=%b exp=0", cyc, out_last); end
      if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset out_data cyc=%0d got=%h exp=0000", cyc, out_data); end
    end
    fq.delete();
  endtask

  task automatic test_single();
    int n_rd, n_v;
    n_rd = 0;
    n_v  = 0;
    tick(1'b1, 1'b0);
    fq.push_back(16'h0025);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1);
      n_rd += int'(rd_en);
      n_v  += int'(out_valid);
      n_cmp += 4;
      if (rd_en !== exp_rd_en) begin n_err++; $display("FAIL single rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd_en); end
      if (out_valid !== exp_valid) begin n_err++; $display("FAIL single out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
      if (out_data !== exp_data) begin n_err++; $display("FAIL single out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data); end
      if (out_last !== exp_last) begin n_err++; $display("FAIL single out_last cyc=%0d got=%b exp=%b", cyc, out_last, exp_last); end
    end
    n_cmp += 2;
    if (n_rd != 1) begin n_err++; $display("FAIL single rd_pulses got=%0d exp=1", n_rd); end
    if (n_v != 1) begin n_err++; $display("FAIL single valid_cycles got=%0d exp=1", n_v); end
  endtask

  task automatic test_stream();
    int n_rd_run;
    logic [W-1:0] lasts[$];
    n_rd_run = 0;
    tick(1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) fq.push_back(W'(k));
    for (int i = 0; i < 13; i++) begin
      tick(1'b1, 1'b1);
      if (rd_en) n_rd_run++;
      if (out_valid && out_last) lasts.push_back(out_data);
      n_cmp += 4;
      if (rd_en !== exp_rd_en) begin n_err++; $display("FAIL stream rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd_en); end
      if (out_valid !== exp_valid) begin n_err++; $display("FAIL stream out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
      if (out_data !== exp_data) begin n_err++; $display("FAIL stream out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data); end
      if (out_last !== exp_last) begin n_err++; $display("FAIL stream out_last cyc=%0d got=%b exp=%b", cyc, out_last, exp_last); end
    end
    n_cmp += 2;
    if (n_rd_run != 8) begin n_err++; $display("FAIL stream rd_count got=%0d exp=8", n_rd_run); end
    if (lasts.size() != 2 || lasts[0] !== 16'h0004 || lasts[1] !== 16'h0008) begin
      n_err++;
      $display("FAIL stream last_words got_n=%0d exp=0004,0008", lasts.size());
    end
  endtask

  task automatic test_backpressure();
    bit pv, pr, pl;
    logic [W-1:0] pd;
    bit rdy;
    pv = 1'b0;
    pr = 1'b1;
    pl = 1'b0;
    pd = '0;
    for (int k = 1; k <= 8; k++) fq.push_back(W'(16'h0040 + k));
    for (int i = 0; i < 20; i++) begin
      rdy = !(i >= 3 && i < 8);
      tick(rdy, 1'b1);
      n_cmp += 4;
      if (rd_en !== exp_rd_en) begin n_err++; $display("FAIL backpressure rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd_en); end
      if (out_valid !== exp_valid) begin n_err++; $display("FAIL backpressure out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
      if (out_data !== exp_data) begin n_err++; $display("FAIL backpressure out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data); end
      if (out_last !== exp_last) begin n_err++; $display("FAIL backpressure out_last cyc=%0d got=%b exp=%b", cyc, out_last, exp_last); end
      if (pv && !pr) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          n_err++;
          $display("FAIL backpressure hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, out_valid, out_data, out_last, pd, pl);
        end
      end
      pv = out_valid;
      pr = rdy;
      pd = out_data;
      pl = out_last;
    end
  endtask

  task automatic test_empty_gap();
    bit saw9;
    saw9 = 1'b0;
    for (int k = 1; k <= 3; k++) fq.push_back(W'(k));
    for (int i = 0; i < 16; i++) begin
      if (i == 10) fq.push_back(16'h0009);
      tick(1'b1, 1'b1);
      if (out_valid && out_data === 16'h0009) saw9 = out_last;
      n_cmp += 4;
      if (rd_en !== exp_rd_en) begin n_err++; $display("FAIL empty_gap rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd_en); end
      if (out_valid !== exp_valid) begin n_err++; $display("FAIL empty_gap out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
      if (out_data !== exp_data) begin n_err++; $display("FAIL empty_gap out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data); end
      if (out_last !== exp_last) begin n_err++; $display("FAIL empty_gap out_last cyc=%0d got=%b exp=%b", cyc, out_last, exp_last); end
    end
    n_cmp++;
    if (!saw9) begin n_err++; $display("FAIL empty_gap last_on_0009 got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    bit l30, l33;
    l30 = 1'b1;
    l33 = 1'b0;
    for (int k = 0; k < 6; k++) fq.push_back(W'(16'h0020 + k));
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    n_cmp++;
    if (dut.w_occ !== 2'd2) begin n_err++; $display("FAIL reset_mid pre_occ got=%0d exp=2", dut.w_occ); end
    tick(1'b0, 1'b0);
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid out_valid got=%b exp=0", out_valid); end
    if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_mid out_data got=%h exp=0000", out_data); end
    fq.delete();
    for (int k = 0; k < 4; k++) fq.push_back(W'(16'h0030 + k));
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1);
      if (out_valid && out_data === 16'h0030) l30 = out_last;
      if (out_valid && out_data === 16'h0033) l33 = out_last;
      n_cmp += 4;
      if (rd_en !== exp_rd_en) begin n_err++; $display("FAIL reset_mid rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd_en); end
      if (out_valid !== exp_valid) begin n_err++; $display("FAIL reset_mid out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
      if (out_data !== exp_data) begin n_err++; $display("FAIL reset_mid out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data); end
      if (out_last !== exp_last) begin n_err++; $display("FAIL reset_mid out_last cyc=%0d got=%b exp=%b", cyc, out_last, exp_last); end
    end
    n_cmp += 2;
    if (l30 !== 1'b0) begin n_err++; $display("FAIL reset_mid last_on_0030 got=%b exp=0", l30); end
    if (l33 !== 1'b1) begin n_err++; $display("FAIL reset_mid last_on_0033 got=%b exp=1", l33); end
  endtask

  task automatic test_random();
    bit rdy;
    for (int i = 0; i < 500; i++) begin
      if (i < 460 && $urandom_range(0, 9) < 6) fq.push_back(W'($urandom));
      rdy = (i >= 460) || ($urandom_range(0, 9) < 7);
      tick(rdy, 1'b1);
      n_cmp += 5;
      if (rd_en !== exp_rd_en) begin n_err++; $display("FAIL random rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd_en); end
      if (out_valid !== exp_valid) begin n_err++; $display("FAIL random out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
      if (out_data !== exp_data) begin n_err++; $display("FAIL random out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data); end
      if (out_last !== exp_last) begin n_err++; $display("FAIL random out_last cyc=%0d got=%b exp=%b", cyc, out_last, exp_last); end
      if (dut.r_inflight[0] && dut.w_occ == 2'd2 && !(out_valid && out_ready)) begin
        n_err++;
        $display("FAIL random capture_overflow cyc=%0d got=occ2_capture exp=none", cyc);
      end
    end
    n_cmp++;
    if (rq_d.size() != 0 || fq.size() != 0) begin
      n_err++;
      $display("FAIL random drain got=%0d/%0d exp=0/0", rq_d.size(), fq.size());
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    rd_data    = '0;
    pend       = 1'b0;
    pend_word  = '0;
    bidx       = 0;
    last_data  = '0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_empty_gap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
